// File: rtl/u_b_pkg.sv
// ----------------------------------------------------------------------------
// u_b_pkg
// Shared types and constants for the potential/beta read-modify-write
// controller: FSM state encoding, default geometry and the helper that
// derives packed word widths from neurons-per-word and per-neuron width.
// No ports.
// ----------------------------------------------------------------------------
package u_b_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CLEAR = 2'd2
   } state_t;

   localparam int DEF_NPW         = 8;
   localparam int DEF_U_W         = 16;
   localparam int DEF_B_W         = 8;
   localparam int DEF_ADDR_W      = 9;
   localparam int DEF_CLEAR_DEPTH = 512;
   localparam int DEF_RD_LAT      = 1;
   localparam int DEF_MAX_OUT     = 4;

   // Width of one SRAM word holding npw neurons of lane_w bits each.
   function automatic int word_w(input int npw, input int lane_w);
      return npw * lane_w;
   endfunction

endpackage

// File: rtl/u_b_addr_scoreboard.sv
// ----------------------------------------------------------------------------
// u_b_addr_scoreboard
// FIFO of in-flight word addresses with a per-entry valid bit and a parallel
// match against a probe address. Used to hold off requests whose address is
// still waiting for its writeback.
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_push/i_push_addr enqueue an address
//   i_pop              dequeue the head (ignored when empty)
//   i_match_addr       probe address; o_match = it equals a valid entry
//   o_full, o_empty    occupancy flags
//   o_head_addr        oldest valid address
// DEPTH must be a power of two, at least 2 (pointers wrap naturally).
// ----------------------------------------------------------------------------
module u_b_addr_scoreboard #(
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_push,
   input  logic [ADDR_W-1:0] i_push_addr,
   input  logic              i_pop,
   input  logic [ADDR_W-1:0] i_match_addr,
   output logic              o_match,
   output logic              o_full,
   output logic              o_empty,
   output logic [ADDR_W-1:0] o_head_addr
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
   logic [DEPTH-1:0]             r_vld;
   logic [PTR_W-1:0]             r_wr_ptr;
   logic [PTR_W-1:0]             r_rd_ptr;
   logic [PTR_W:0]               r_count;

   logic w_pop;
   logic w_push;
   logic w_match;

   assign o_empty     = (r_count == '0);
   assign o_full      = (r_count == (PTR_W+1)'(DEPTH));
   assign o_head_addr = r_addr[r_rd_ptr];
   assign o_match     = w_match;

   assign w_pop  = i_pop && !o_empty;
   // A push into a full FIFO is fine when the head leaves in the same cycle.
   assign w_push = i_push && (!o_full || w_pop);

   // Match uses current occupancy, so an entry retiring this cycle still hits.
   always_comb begin
      w_match = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_vld[i] && (r_addr[i] == i_match_addr)) w_match = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_vld    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_pop) begin
            r_vld[r_rd_ptr] <= 1'b0;
            r_rd_ptr        <= r_rd_ptr + 1'b1;
         end
         // Push after pop so a full-FIFO push/pop into the same slot keeps it valid.
         if (w_push) begin
            r_vld[r_wr_ptr]  <= 1'b1;
            r_addr[r_wr_ptr] <= i_push_addr;
            r_wr_ptr         <= r_wr_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/u_b_rmw_controller.sv
// ----------------------------------------------------------------------------
// u_b_rmw_controller
// Read-modify-write controller for the potential/beta neuron SRAMs.
// Accepts word update requests, issues matched potential/beta reads, returns
// the data RD_LAT cycles later to the neuron datapath, and forwards updated
// potentials to the SRAM write port. An address scoreboard blocks
// read-after-write hazards; a clear sweep zeroes potentials 0..CLEAR_DEPTH-1.
// Ports:
//   i_clk, i_reset                      clock, synchronous active-high reset
//   i_req_valid/o_req_ready/i_req_addr  update request handshake
//   o_potential_read_sram_addr, i_potential_read_sram   potential read port
//   o_beta_read_sram_addr, i_beta_read_sram             beta read port
//   o_rd_valid/o_rd_addr/o_rd_pot/o_rd_beta             returned read data
//   i_wr_valid/i_wr_addr/i_wr_pot       writeback from the neuron datapath
//   o_potential_write_sram(_addr/_we)   potential SRAM write port
//   i_clear_start/o_clear_done          zero sweep start / completion pulse
//   o_busy                              not IDLE
//   o_wb_err                            sticky writeback ordering error
// Optional: define U_B_WB_CHECK_EN to check writebacks against the
// scoreboard head (bad writes are dropped and flagged on o_wb_err).
// ----------------------------------------------------------------------------
module u_b_rmw_controller
   import u_b_pkg::*;
#(
   parameter int NPW         = DEF_NPW,
   parameter int U_W         = DEF_U_W,
   parameter int B_W         = DEF_B_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int CLEAR_DEPTH = DEF_CLEAR_DEPTH,
   parameter int RD_LAT      = DEF_RD_LAT,
   parameter int MAX_OUT     = DEF_MAX_OUT,
   parameter int POT_W       = word_w(NPW, U_W),
   parameter int BETA_W      = word_w(NPW, B_W)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [ADDR_W-1:0] i_req_addr,
   output logic [ADDR_W-1:0] o_potential_read_sram_addr,
   input  logic [POT_W-1:0]  i_potential_read_sram,
   output logic [ADDR_W-1:0] o_beta_read_sram_addr,
   input  logic [BETA_W-1:0] i_beta_read_sram,
   output logic              o_rd_valid,
   output logic [ADDR_W-1:0] o_rd_addr,
   output logic [POT_W-1:0]  o_rd_pot,
   output logic [BETA_W-1:0] o_rd_beta,
   input  logic              i_wr_valid,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [POT_W-1:0]  i_wr_pot,
   output logic [POT_W-1:0]  o_potential_write_sram,
   output logic [ADDR_W-1:0] o_potential_write_sram_addr,
   output logic              o_potential_write_sram_we,
   input  logic              i_clear_start,
   output logic              o_clear_done,
   output logic              o_busy,
   output logic              o_wb_err
);

   localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(CLEAR_DEPTH - 1);

   state_t                       r_state;
   logic [RD_LAT-1:0]            r_vld_pipe;
   logic [RD_LAT-1:0][ADDR_W-1:0] r_addr_pipe;
   logic [ADDR_W-1:0]            r_clr_addr;
   logic                         r_clear_done;

   logic              w_sb_match;
   logic              w_sb_full;
   logic              w_sb_empty;
   logic [ADDR_W-1:0] w_sb_head;
   logic              w_clr_go;
   logic              w_req_ready;
   logic              w_accept;
   logic              w_wb_ok;
   logic              w_wb_fire;

   // clear_start wins over a same-cycle request in IDLE so the sweep never
   // starts with a read-modify-write in flight.
   assign w_clr_go    = (r_state == IDLE) && i_clear_start;
   assign w_req_ready = !i_reset && (r_state != CLEAR) && !w_clr_go &&
                        !w_sb_full && !w_sb_match;
   assign w_accept    = i_req_valid && w_req_ready;

`ifdef U_B_WB_CHECK_EN
   assign w_wb_ok = !w_sb_empty && (i_wr_addr == w_sb_head);
`else
   assign w_wb_ok = 1'b1;
   logic w_unused_head;
   assign w_unused_head = ^w_sb_head;
`endif

   assign w_wb_fire = !i_reset && i_wr_valid && (r_state != CLEAR) && w_wb_ok;

   u_b_addr_scoreboard #(
      .ADDR_W (ADDR_W),
      .DEPTH  (MAX_OUT)
   ) u_sb (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_push       (w_accept),
      .i_push_addr  (i_req_addr),
      .i_pop        (w_wb_fire),
      .i_match_addr (i_req_addr),
      .o_match      (w_sb_match),
      .o_full       (w_sb_full),
      .o_empty      (w_sb_empty),
      .o_head_addr  (w_sb_head)
   );

   assign o_req_ready                = w_req_ready;
   assign o_potential_read_sram_addr = i_req_addr;
   assign o_beta_read_sram_addr      = i_req_addr;
   assign o_rd_valid                 = r_vld_pipe[RD_LAT-1];
   assign o_rd_addr                  = r_addr_pipe[RD_LAT-1];
   assign o_rd_pot                   = i_potential_read_sram;
   assign o_rd_beta                  = i_beta_read_sram;
   assign o_clear_done               = r_clear_done;
   assign o_busy                     = (r_state != IDLE);

   // Write port: sweep owns it in CLEAR, otherwise datapath pass-through.
   always_comb begin
      o_potential_write_sram_we   = w_wb_fire;
      o_potential_write_sram_addr = i_wr_addr;
      o_potential_write_sram      = i_wr_pot;
      if (r_state == CLEAR) begin
         o_potential_write_sram_we   = !i_reset;
         o_potential_write_sram_addr = r_clr_addr;
         o_potential_write_sram      = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= IDLE;
         r_clr_addr   <= '0;
         r_clear_done <= 1'b0;
         r_vld_pipe   <= '0;
         r_addr_pipe  <= '0;
      end else begin
         r_clear_done   <= 1'b0;
         // Valid/address delay line aligns rd_valid with SRAM read latency.
         r_vld_pipe[0]  <= w_accept;
         r_addr_pipe[0] <= i_req_addr;
         for (int i = 1; i < RD_LAT; i++) begin
            r_vld_pipe[i]  <= r_vld_pipe[i-1];
            r_addr_pipe[i] <= r_addr_pipe[i-1];
         end
         case (r_state)
            IDLE: begin
               if (w_clr_go) begin
                  r_state    <= CLEAR;
                  r_clr_addr <= '0;
               end else if (w_accept) begin
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (w_sb_empty && !w_accept) r_state <= IDLE;
            end
            CLEAR: begin
               if (r_clr_addr == LAST_CLR) begin
                  r_state      <= IDLE;
                  r_clear_done <= 1'b1;
               end else begin
                  r_clr_addr <= r_clr_addr + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef U_B_WB_CHECK_EN
   logic r_wb_err;
   always_ff @(posedge i_clk) begin
      if (i_reset)                                          r_wb_err <= 1'b0;
      else if (w_clr_go)                                    r_wb_err <= 1'b0;
      else if (i_wr_valid && (r_state != CLEAR) && !w_wb_ok) r_wb_err <= 1'b1;
   end
   assign o_wb_err = r_wb_err;
`else
   assign o_wb_err = 1'b0;
`endif

endmodule

// File: tb/tb_u_b_rmw_controller.sv
// ----------------------------------------------------------------------------
// tb_u_b_rmw_controller
// Directed self-checking bench for u_b_rmw_controller (CLEAR_DEPTH=16,
// RD_LAT=1, MAX_OUT=4). Inputs are driven 1 time unit after the rising
// edge and outputs are sampled on the falling edge. A registered SRAM
// model returns address-derived data so returned words can be predicted.
// ----------------------------------------------------------------------------
module tb_u_b_rmw_controller;

   localparam int ADDR_W = 9;
   localparam int POT_W  = 128;
   localparam int BETA_W = 64;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [ADDR_W-1:0] pot_raddr;
   logic [POT_W-1:0]  pot_rdata;
   logic [ADDR_W-1:0] beta_raddr;
   logic [BETA_W-1:0] beta_rdata;
   logic              rd_valid;
   logic [ADDR_W-1:0] rd_addr;
   logic [POT_W-1:0]  rd_pot;
   logic [BETA_W-1:0] rd_beta;
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [POT_W-1:0]  wr_pot;
   logic [POT_W-1:0]  sram_wdata;
   logic [ADDR_W-1:0] sram_waddr;
   logic              sram_we;
   logic              clear_start;
   logic              clear_done;
   logic              busy;
   logic              wb_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   u_b_rmw_controller #(
      .NPW(8), .U_W(16), .B_W(8), .ADDR_W(ADDR_W),
      .CLEAR_DEPTH(16), .RD_LAT(1), .MAX_OUT(4)
   ) dut (
      .i_clk                       (clk),
      .i_reset                     (reset),
      .i_req_valid                 (req_valid),
      .o_req_ready                 (req_ready),
      .i_req_addr                  (req_addr),
      .o_potential_read_sram_addr  (pot_raddr),
      .i_potential_read_sram       (pot_rdata),
      .o_beta_read_sram_addr       (beta_raddr),
      .i_beta_read_sram            (beta_rdata),
      .o_rd_valid                  (rd_valid),
      .o_rd_addr                   (rd_addr),
      .o_rd_pot                    (rd_pot),
      .o_rd_beta                   (rd_beta),
      .i_wr_valid                  (wr_valid),
      .i_wr_addr                   (wr_addr),
      .i_wr_pot                    (wr_pot),
      .o_potential_write_sram      (sram_wdata),
      .o_potential_write_sram_addr (sram_waddr),
      .o_potential_write_sram_we   (sram_we),
      .i_clear_start               (clear_start),
      .o_clear_done                (clear_done),
      .o_busy                      (busy),
      .o_wb_err                    (wb_err)
   );

   // One-cycle-latency SRAM model: word content is derived from its address.
   always @(posedge clk) begin
      pot_rdata  <= {8{7'd0, pot_raddr}};
      beta_rdata <= {8{beta_raddr[7:0]}};
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0; req_addr = '0; wr_valid = 1'b0; wr_addr = '0;
      wr_pot = '0; clear_start = 1'b0;
   endtask

   task automatic test_reset();
      logic [ADDR_W+5:0] got;
      idle_inputs();
      reset = 1'b1;
      tick(); tick();
      @(negedge clk);
      got = {req_ready, rd_valid, sram_we, busy, clear_done, wb_err, rd_addr};
      n_checks++;
      if (got !== '0) begin
         n_errors++; $display("FAIL reset_outs got %h exp 0", got);
      end
      reset = 1'b0;
      tick();
      @(negedge clk);
      n_checks++;
      if ({req_ready, busy} !== 2'b10) begin
         n_errors++; $display("FAIL post_reset got %b exp 10", {req_ready, busy});
      end
   endtask

   task automatic test_back_to_back();
      logic [ADDR_W-1:0] a;
      logic [15:0]       h;
      for (int k = 0; k < 6; k++) begin
         tick();
         idle_inputs();
         if (k < 4) begin
            req_valid = 1'b1;
            req_addr  = ADDR_W'(3 + k);
         end
         clear_start = (k == 1);  // must be ignored in RUN
         @(negedge clk);
         if (k < 4) begin
            n_checks++;
            if ({req_ready, pot_raddr, beta_raddr} !== {1'b1, req_addr, req_addr}) begin
               n_errors++; $display("FAIL b2b_issue k=%0d got %b/%0d exp 1/%0d", k, req_ready, pot_raddr, req_addr);
            end
         end
         n_checks++;
         if ({rd_valid, sram_we} !== {(k >= 1 && k <= 4), 1'b0}) begin
            n_errors++; $display("FAIL b2b_rdv k=%0d got %b exp %b", k, {rd_valid, sram_we}, {(k >= 1 && k <= 4), 1'b0});
         end
         if (k >= 1 && k <= 4) begin
            a = ADDR_W'(3 + k - 1);
            n_checks++;
            if ({rd_addr, rd_pot, rd_beta} !== {a, {8{7'd0, a}}, {8{a[7:0]}}}) begin
               n_errors++; $display("FAIL b2b_rdata k=%0d got addr %0d exp %0d", k, rd_addr, a);
            end
         end
      end
      for (int j = 0; j < 4; j++) begin
         tick();
         idle_inputs();
         h = 16'hA000 + 16'(j);
         wr_valid = 1'b1; wr_addr = ADDR_W'(3 + j); wr_pot = {8{h}};
         @(negedge clk);
         n_checks++;
         if ({sram_we, sram_waddr, sram_wdata} !== {1'b1, wr_addr, {8{h}}}) begin
            n_errors++; $display("FAIL b2b_wb j=%0d got we %b addr %0d exp 1 %0d", j, sram_we, sram_waddr, wr_addr);
         end
      end
      tick(); idle_inputs();
      @(negedge clk);
      n_checks++;
      if ({sram_we, busy} !== 2'b01) begin
         n_errors++; $display("FAIL b2b_drain got %b exp 01", {sram_we, busy});
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++; $display("FAIL b2b_idle got busy %b exp 0", busy);
      end
   endtask

   task automatic test_hazard();
      for (int c = 0; c < 7; c++) begin
         tick();
         idle_inputs();
         req_valid = (c <= 4); req_addr = 9'd7;
         wr_valid  = (c == 3 || c == 6); wr_addr = 9'd7;
         @(negedge clk);
         n_checks++;
         if ({req_ready, sram_we, rd_valid} !== {(c == 0 || c == 4), (c == 3 || c == 6), (c == 1 || c == 5)}) begin
            n_errors++; $display("FAIL hazard c=%0d got %b exp %b", c, {req_ready, sram_we, rd_valid},
                                 {(c == 0 || c == 4), (c == 3 || c == 6), (c == 1 || c == 5)});
         end
      end
      tick(); idle_inputs();
      tick();
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++; $display("FAIL hazard_idle got busy %b exp 0", busy);
      end
   endtask

   task automatic test_full();
      for (int c = 0; c < 9; c++) begin
         tick();
         idle_inputs();
         req_valid = 1'b1;
         req_addr  = (c < 4) ? ADDR_W'(10 + c) : ((c < 8) ? 9'd14 : 9'd15);
         wr_valid  = (c == 6); wr_addr = 9'd10;
         @(negedge clk);
         n_checks++;
         if (req_ready !== (c < 4 || c == 7)) begin
            n_errors++; $display("FAIL full_ready c=%0d got %b exp %b", c, req_ready, (c < 4 || c == 7));
         end
      end
      for (int j = 0; j < 4; j++) begin
         tick();
         idle_inputs();
         wr_valid = 1'b1; wr_addr = ADDR_W'(11 + j);
         @(negedge clk);
         n_checks++;
         if ({sram_we, sram_waddr} !== {1'b1, wr_addr}) begin
            n_errors++; $display("FAIL full_wb j=%0d got %b %0d exp 1 %0d", j, sram_we, sram_waddr, wr_addr);
         end
      end
      tick(); idle_inputs();
      tick();
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++; $display("FAIL full_idle got busy %b exp 0", busy);
      end
   endtask

   task automatic test_clear();
      logic [ADDR_W+3:0] got;
      logic [ADDR_W+3:0] exp;
      tick(); idle_inputs();
      clear_start = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({req_ready, sram_we} !== 2'b00) begin
         n_errors++; $display("FAIL clr_start got %b exp 00", {req_ready, sram_we});
      end
      for (int c = 1; c <= 18; c++) begin
         tick(); idle_inputs();
         @(negedge clk);
         got = {req_ready, sram_we, busy, clear_done, sram_waddr};
         if (c <= 16)      exp = {4'b0110, ADDR_W'(c - 1)};
         else if (c == 17) exp = {4'b1001, sram_waddr};
         else              exp = {4'b1000, sram_waddr};
         n_checks++;
         if (got !== exp) begin
            n_errors++; $display("FAIL clr_seq c=%0d got %h exp %h", c, got, exp);
         end
         if (c <= 16) begin
            n_checks++;
            if (sram_wdata !== '0) begin
               n_errors++; $display("FAIL clr_data c=%0d got %h exp 0", c, sram_wdata);
            end
         end
      end
   endtask

   task automatic test_reset_in_clear();
      tick(); idle_inputs();
      clear_start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick(); idle_inputs();
      end
      @(negedge clk);
      n_checks++;
      if ({sram_we, sram_waddr} !== {1'b1, 9'd5}) begin
         n_errors++; $display("FAIL rstclr_pre got %b %0d exp 1 5", sram_we, sram_waddr);
      end
      reset = 1'b1;
      tick();
      @(negedge clk);
      n_checks++;
      if ({sram_we, busy, clear_done} !== 3'b000) begin
         n_errors++; $display("FAIL rstclr_abort got %b exp 000", {sram_we, busy, clear_done});
      end
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         @(negedge clk);
         n_checks++;
         if ({sram_we, busy, clear_done} !== 3'b000) begin
            n_errors++; $display("FAIL rstclr_quiet c=%0d got %b exp 000", c, {sram_we, busy, clear_done});
         end
      end
   endtask

   task automatic test_wb_check();
      tick(); idle_inputs();
      req_valid = 1'b1; req_addr = 9'd2;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_errors++; $display("FAIL wb_req got %b exp 1", req_ready);
      end
      tick(); idle_inputs();
      tick(); idle_inputs();
      wr_valid = 1'b1; wr_addr = 9'd9;
      @(negedge clk);
`ifdef U_B_WB_CHECK_EN
      n_checks++;
      if (sram_we !== 1'b0) begin
         n_errors++; $display("FAIL wb_bad_we got %b exp 0", sram_we);
      end
      tick(); idle_inputs();
      @(negedge clk);
      n_checks++;
      if ({wb_err, busy} !== 2'b11) begin
         n_errors++; $display("FAIL wb_err_set got %b exp 11", {wb_err, busy});
      end
      tick(); idle_inputs();
      wr_valid = 1'b1; wr_addr = 9'd2;
      @(negedge clk);
      n_checks++;
      if ({sram_we, sram_waddr} !== {1'b1, 9'd2}) begin
         n_errors++; $display("FAIL wb_good got %b %0d exp 1 2", sram_we, sram_waddr);
      end
      tick(); idle_inputs();
      tick(); idle_inputs();
      clear_start = 1'b1;
      tick(); idle_inputs();
      @(negedge clk);
      n_checks++;
      if ({wb_err, busy} !== 2'b01) begin
         n_errors++; $display("FAIL wb_err_clr got %b exp 01", {wb_err, busy});
      end
      for (int c = 0; c < 16; c++) tick();
      @(negedge clk);
      n_checks++;
      if ({clear_done, busy} !== 2'b10) begin
         n_errors++; $display("FAIL wb_clr_done got %b exp 10", {clear_done, busy});
      end
`else
      n_checks++;
      if ({sram_we, sram_waddr} !== {1'b1, 9'd9}) begin
         n_errors++; $display("FAIL wb_unchk_we got %b %0d exp 1 9", sram_we, sram_waddr);
      end
      tick(); idle_inputs();
      @(negedge clk);
      n_checks++;
      if ({wb_err, busy} !== 2'b01) begin
         n_errors++; $display("FAIL wb_unchk_err got %b exp 01", {wb_err, busy});
      end
      tick(); idle_inputs();
      req_valid = 1'b1; req_addr = 9'd2;
      @(negedge clk);
      n_checks++;
      if ({req_ready, busy} !== 2'b10) begin
         n_errors++; $display("FAIL wb_unchk_pop got %b exp 10", {req_ready, busy});
      end
      tick(); idle_inputs();
      tick(); idle_inputs();
      wr_valid = 1'b1; wr_addr = 9'd2;
      tick(); idle_inputs();
      tick();
      @(negedge clk);
      n_checks++;
      if ({busy, wb_err} !== 2'b00) begin
         n_errors++; $display("FAIL wb_unchk_idle got %b exp 00", {busy, wb_err});
      end
`endif
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_back_to_back();
      test_hazard();
      test_full();
      test_clear();
      test_reset_in_clear();
      test_wb_check();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/u_b_rmw_controller.md
Name: u_b_rmw_controller

Overview:
- Sequential successor to the combinational potential/beta memory controller.
- Accepts neuron-word update requests with a valid/ready handshake and issues matched potential and beta SRAM reads.
- Aligns the returned data to the SRAM read latency and presents it to the neuron update datapath, then writes updated potentials back.
- Blocks read-after-write hazards with an in-flight address scoreboard and provides a zero-fill sweep that clears potentials between inferences.

Parameters:
- NPW, 8, neurons per SRAM word.
- U_W, 16, potential bits per neuron; POT_W = NPW*U_W (128).
- B_W, 8, beta bits per neuron; BETA_W = NPW*B_W (64).
- ADDR_W, 9, SRAM word address width.
- CLEAR_DEPTH, 512, number of words zeroed by a clear sweep (must be at most 2**ADDR_W).
- RD_LAT, 1, SRAM read latency in cycles (1..3).
- MAX_OUT, 4, maximum outstanding read-modify-write operations (power of 2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  update request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  ADDR_W  word to update.
- potential_read_sram_addr  out  ADDR_W  potential SRAM read address.
- potential_read_sram  in  POT_W  potential SRAM read data.
- beta_read_sram_addr  out  ADDR_W  beta SRAM read address.
- beta_read_sram  in  BETA_W  beta SRAM read data.
- rd_valid  out  1  read data valid; no backpressure.
- rd_addr  out  ADDR_W  address of the returned data.
- rd_pot  out  POT_W  potential word.
- rd_beta  out  BETA_W  beta word.
- wr_valid  in  1  writeback from the neuron datapath.
- wr_addr  in  ADDR_W  writeback address.
- wr_pot  in  POT_W  updated potential word.
- potential_write_sram  out  POT_W  SRAM write data.
- potential_write_sram_addr  out  ADDR_W  SRAM write address.
- potential_write_sram_we  out  1  SRAM write enable.
- clear_start  in  1  pulse that starts a zero sweep.
- clear_done  out  1  one-cycle pulse when the sweep completes.
- busy  out  1  high in CLEAR, or when any operation is in flight.
- wb_err  out  1  sticky writeback ordering error.

Behaviour:
- Reset:
  - All outputs are 0 and the FSM goes to IDLE.
  - The scoreboard and the read-latency delay line are emptied.
  - Reset during CLEAR aborts the sweep; clear_done is not pulsed.
- FSM states: IDLE, RUN, CLEAR.
  - IDLE→RUN on an accepted request.
  - RUN→IDLE when the scoreboard is empty and no request is accepted.
  - IDLE→CLEAR on clear_start.
  - clear_start is ignored in RUN.
  - CLEAR→IDLE after the write to address CLEAR_DEPTH-1; clear_done pulses the following cycle.
- req_ready = (state != CLEAR) && scoreboard not full && req_addr matches no valid scoreboard entry.
  - The match uses occupancy before a same-cycle pop, so a request to the retiring address stalls exactly one cycle.
  - req_ready must not depend on wr_valid combinationally.
- Read issue:
  - Both read SRAM addresses are driven combinationally from req_addr.
  - On acceptance, req_addr is pushed into the scoreboard FIFO and into an RD_LAT-deep valid/address delay line.
- Read return:
  - rd_valid and rd_addr exit the delay line exactly RD_LAT cycles after acceptance.
  - rd_pot and rd_beta pass through combinationally from the SRAM data.
  - Throughput is one request per cycle with no hazards.
- Writeback:
  - wr_valid drives potential_write_sram_we in the same cycle, with wr_addr and wr_pot passed through to the SRAM write port.
  - Each writeback pops the scoreboard head; writebacks must arrive in request order.
- CLEAR:
  - Writes zero to addresses 0..CLEAR_DEPTH-1, one per cycle, with we=1.
  - req_ready=0 throughout, and wr_valid is not expected.
  - clear_start also clears wb_err.
- Scoreboard: a MAX_OUT-entry FIFO of addresses with a per-entry valid bit; pointer wrap is modulo MAX_OUT.
  - Push and pop in the same cycle while full is legal.
- busy = (state != IDLE).

Optional Feature:
- U_B_WB_CHECK_EN defined:
  - A wr_valid with an empty scoreboard, or with wr_addr != head address, sets wb_err.
  - That write is suppressed (we=0) and nothing is popped.
- Not defined: writebacks are unchecked, the head is always popped, and wb_err is tied 0.

Decomposition:
- Package u_b_pkg holds:
  - the state enum (IDLE, RUN, CLEAR);
  - the POT_W/BETA_W derivation constants;
  - default ADDR_W and CLEAR_DEPTH.
- One sub-module, u_b_addr_scoreboard: a parametrised address FIFO with a parallel match output, full and empty flags, and push/pop.

Test Plan:
- Requests to addresses 3,4,5,6 on back-to-back cycles, RD_LAT=1 → rd_valid on cycles 1–4 with rd_addr 3..6; writebacks in order produce we=1 with matching addresses.
- Request to 7, then to 7 again before its writeback → second req_ready=0 until the cycle after wr_valid for 7; it is accepted one cycle after the pop.
- Five requests with no writebacks, MAX_OUT=4 → the fifth stalls; one writeback lets it be accepted the next cycle.
- clear_start in IDLE, CLEAR_DEPTH=16 → 16 consecutive writes of 0 to addresses 0..15, clear_done pulses on cycle 17, req_ready=0 throughout.
- Reset asserted at sweep address 5 → we=0 next cycle, no clear_done, busy=0.
- With U_B_WB_CHECK_EN: request 2, then writeback to 9 → wb_err=1, no SRAM write; a following clear_start clears wb_err.
